rgb_led_pwm: RTL and testbench

Parametrised RGB LED driver between the SoC LED register and the board RGB LED pins. It generalises the fixed 2-bit-per-LED colour mapping to NUM_LEDS LEDs with per-channel PWM brightness.
- Two modes:
  - Legacy mode reproduces the direct code-to-colour mapping.
  - PWM mode drives each R/G/B channel from a DUTY_W-bit duty register written over a simple write port.
- Duty updates are double-buffered and applied only at PWM period boundaries, so there is no visible glitch.

---
 rtl/rgb_led_pwm.sv | 121 ++++++++++++
 tb/tb_rgb_led_pwm.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_led_pwm.sv
// rgb_led_pwm
// Drives NUM_LEDS RGB LEDs (3*NUM_LEDS channels) from the SoC LED register.
// Legacy mode maps a 2-bit colour code per LED straight onto the R/G/B pins.
// PWM mode gives every channel a DUTY_W-bit duty cycle. Duties are written
// into a pending bank and copied to the active bank only when the PWM counter
// wraps, so a duty change never produces a partial period.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   pwm_mode     0 = legacy code mapping, 1 = PWM duty mode
//   code         legacy colour code, 2 bits per LED
//   wr_valid     duty write strobe
//   wr_addr      channel index = colour*NUM_LEDS + led (0=R, 1=G, 2=B)
//   wr_data      duty value
//   wr_err       sticky flag, set by a write to a nonexistent channel
//   period_start one-cycle pulse in the cycle after the PWM counter wraps
//   led          channel outputs: [i]=R, [NUM_LEDS+i]=G, [2*NUM_LEDS+i]=B
module rgb_led_pwm #(
  parameter int NUM_LEDS = 4,
  parameter int DUTY_W   = 8,
  parameter int PRESCALE = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          pwm_mode,
  input  logic [2*NUM_LEDS-1:0]         code,
  input  logic                          wr_valid,
  input  logic [$clog2(3*NUM_LEDS)-1:0] wr_addr,
  input  logic [DUTY_W-1:0]             wr_data,
  output logic                          wr_err,
  output logic                          period_start,
  output logic [3*NUM_LEDS-1:0]         led
);

  localparam int NUM_CH = 3 * NUM_LEDS;
  localparam int AW     = $clog2(NUM_CH);
  localparam int PS_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [PS_W-1:0]   PS_LAST  = PS_W'(PRESCALE - 1);
  localparam logic [DUTY_W-1:0] DUTY_MAX = '1;
  localparam logic [AW:0]       NUM_CH_L = (AW + 1)'(NUM_CH);

  logic [PS_W-1:0]     prescaler_q, prescaler_d;
  logic [DUTY_W-1:0]   pwm_cnt_q, pwm_cnt_d;
  logic                period_start_q, period_start_d;
  logic                wr_err_q, wr_err_d;
  logic [NUM_CH-1:0]   led_q, led_d;
  logic [DUTY_W-1:0]   pending_q [NUM_CH];
  logic [DUTY_W-1:0]   pending_d [NUM_CH];
  logic [DUTY_W-1:0]   active_q  [NUM_CH];
  logic [DUTY_W-1:0]   active_d  [NUM_CH];

  logic tick;
  logic boundary;
  logic wr_addr_ok;

  always_comb begin
    tick       = (prescaler_q == PS_LAST);
    // The tick that moves the counter from all-ones back to zero ends a period.
    boundary   = tick && (pwm_cnt_q == DUTY_MAX);
    wr_addr_ok = ({1'b0, wr_addr} < NUM_CH_L);

    prescaler_d    = tick ? '0 : prescaler_q + 1'b1;
    pwm_cnt_d      = tick ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
    period_start_d = boundary;
    wr_err_d       = wr_err_q | (wr_valid & ~wr_addr_ok);

    pending_d = pending_q;
    active_d  = active_q;
    // The shadow copy reads the pending bank as it was before this cycle's
    // write, so a write on the boundary cycle waits one more period.
    if (boundary) begin
      active_d = pending_q;
    end
    if (wr_valid && wr_addr_ok) begin
      pending_d[wr_addr] = wr_data;
    end

    led_d = '0;
    if (pwm_mode) begin
      // All-ones duty means fully on; a plain compare would leave one tick dark.
      for (int ch = 0; ch < NUM_CH; ch++) begin
        led_d[ch] = (active_q[ch] == DUTY_MAX) | (pwm_cnt_q < active_q[ch]);
      end
    end else begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        led_d[i]              = code[2*i];
        led_d[NUM_LEDS + i]   = code[2*i + 1];
        led_d[2*NUM_LEDS + i] = code[2*i] & code[2*i + 1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescaler_q    <= '0;
      pwm_cnt_q      <= '0;
      period_start_q <= 1'b0;
      wr_err_q       <= 1'b0;
      led_q          <= '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        pending_q[ch] <= '0;
        active_q[ch]  <= '0;
      end
    end else begin
      prescaler_q    <= prescaler_d;
      pwm_cnt_q      <= pwm_cnt_d;
      period_start_q <= period_start_d;
      wr_err_q       <= wr_err_d;
      led_q          <= led_d;
      pending_q      <= pending_d;
      active_q       <= active_d;
    end
  end

  assign wr_err       = wr_err_q;
  assign period_start = period_start_q;
  assign led          = led_q;

endmodule

// File: tb/tb_rgb_led_pwm.sv
// tb_rgb_led_pwm
// Scoreboard bench for rgb_led_pwm with NUM_LEDS=4, DUTY_W=4, PRESCALE=2,
// giving a 16-tick period of 32 clk cycles. Each driven cycle pushes the
// expected led / period_start / wr_err for the following edge; the entry is
// popped and compared once that edge has happened.
module tb_rgb_led_pwm;

  localparam int NUM_LEDS   = 4;
  localparam int DUTY_W     = 4;
  localparam int PRESCALE   = 2;
  localparam int NCH        = 3 * NUM_LEDS;
  localparam int PERIOD_CYC = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        pwm_mode;
  logic [7:0]  code;
  logic        wr_valid;
  logic [3:0]  wr_addr;
  logic [3:0]  wr_data;
  logic        wr_err;
  logic        period_start;
  logic [11:0] led;

  typedef struct packed {
    logic [11:0] led;
    logic        ps;
    logic        err;
  } exp_t;

  exp_t        expQ[$];
  int          total = 0;
  int          bad = 0;
  int unsigned cyc = 0;
  logic [3:0]  modelPending [NCH];
  logic [3:0]  modelActive  [NCH];
  logic        modelErr;
  int          highCnt [NCH];

  rgb_led_pwm #(
    .NUM_LEDS(NUM_LEDS),
    .DUTY_W  (DUTY_W),
    .PRESCALE(PRESCALE)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pwm_mode    (pwm_mode),
    .code        (code),
    .wr_valid    (wr_valid),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_err      (wr_err),
    .period_start(period_start),
    .led         (led)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Safety net in case the flow below ever stalls.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Counts one comparison and reports it when the values differ.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got %0h required %0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // Colour-code lookup: 00 off, 01 red, 10 green, 11 white.
  function automatic logic [11:0] legacyLed(input logic [7:0] c);
    logic [11:0] r;
    logic [1:0]  pair;
    r = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      pair = c[2*i +: 2];
      case (pair)
        2'b01: r[i] = 1'b1;
        2'b10: r[NUM_LEDS + i] = 1'b1;
        2'b11: begin
          r[i]              = 1'b1;
          r[NUM_LEDS + i]   = 1'b1;
          r[2*NUM_LEDS + i] = 1'b1;
        end
        default: ;
      endcase
    end
    return r;
  endfunction

  // Returns the model to its post-reset contents.
  task automatic modelReset();
    for (int ch = 0; ch < NCH; ch++) begin
      modelPending[ch] = '0;
      modelActive[ch]  = '0;
    end
    modelErr = 1'b0;
    cyc      = 0;
    expQ.delete();
  endtask

  // Predicts the next edge from the current inputs, then lets that edge
  // happen and compares. cyc counts edges since reset release, so the
  // counter value held during cycle n is (n/2)%16 and edges 32,64,... wrap it.
  task automatic stepCycle();
    exp_t e;
    exp_t got;
    int   cntBefore;
    cntBefore = int'((cyc / 2) % 16);
    e.led = '0;
    if (pwm_mode) begin
      for (int ch = 0; ch < NCH; ch++) begin
        e.led[ch] = (modelActive[ch] == 4'hF) ? 1'b1 : (cntBefore < int'(modelActive[ch]));
      end
    end else begin
      e.led = legacyLed(code);
    end
    e.ps = (((cyc + 1) % PERIOD_CYC) == 0);
    if (e.ps) begin
      for (int ch = 0; ch < NCH; ch++) modelActive[ch] = modelPending[ch];
    end
    if (wr_valid) begin
      if (int'(wr_addr) < NCH) modelPending[wr_addr] = wr_data;
      else modelErr = 1'b1;
    end
    e.err = modelErr;
    expQ.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    got = expQ.pop_front();
    checkOutput("led", 32'(led), 32'(got.led));
    checkOutput("period_start", 32'(period_start), 32'(got.ps));
    checkOutput("wr_err", 32'(wr_err), 32'(got.err));
  endtask

  // Drives one cycle of inputs and checks the resulting edge.
  task automatic applyStimulus(input logic m, input logic [7:0] c, input logic v,
                               input logic [3:0] a, input logic [3:0] d);
    pwm_mode = m;
    code     = c;
    wr_valid = v;
    wr_addr  = a;
    wr_data  = d;
    stepCycle();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(pwm_mode, code, 1'b0, 4'd0, 4'd0);
  endtask

  task automatic toBoundary();
    while ((cyc % PERIOD_CYC) != 0) idle(1);
  endtask

  // Runs one full period and tallies high cycles per channel.
  task automatic countPeriod();
    for (int ch = 0; ch < NCH; ch++) highCnt[ch] = 0;
    for (int k = 0; k < PERIOD_CYC; k++) begin
      idle(1);
      for (int ch = 0; ch < NCH; ch++) highCnt[ch] += int'(led[ch]);
    end
  endtask

  initial begin
    int firstPs;
    reset    = 1'b1;
    pwm_mode = 1'b0;
    code     = '0;
    wr_valid = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_led", 32'(led), 32'd0);
    checkOutput("rst_period_start", 32'(period_start), 32'd0);
    checkOutput("rst_wr_err", 32'(wr_err), 32'd0);
    reset = 1'b0;

    // Legacy mapping, including the fixed example pattern.
    applyStimulus(1'b0, 8'b11_01_10_00, 1'b0, 4'd0, 4'd0);
    checkOutput("legacy_pattern", 32'(led), 32'(12'b1000_1010_1100));
    applyStimulus(1'b0, 8'h00, 1'b0, 4'd0, 4'd0);
    checkOutput("legacy_zero", 32'(led), 32'd0);
    for (int k = 0; k < 4; k++) applyStimulus(1'b0, 8'($urandom), 1'b0, 4'd0, 4'd0);

    // Duty 4 on red LED0: dark until the boundary, then 8 high cycles.
    applyStimulus(1'b1, 8'h00, 1'b1, 4'd0, 4'd4);
    toBoundary();
    countPeriod();
    checkOutput("duty4_high", 32'(highCnt[0]), 32'd8);

    // Duty 0 stays dark, all-ones stays lit.
    applyStimulus(1'b1, 8'h00, 1'b1, 4'd5, 4'd0);
    applyStimulus(1'b1, 8'h00, 1'b1, 4'd10, 4'd15);
    toBoundary();
    countPeriod();
    checkOutput("duty0_high", 32'(highCnt[5]), 32'd0);
    checkOutput("dutymax_high", 32'(highCnt[10]), 32'd32);

    // Write landing on the boundary edge itself.
    idle(PERIOD_CYC - 1);
    applyStimulus(1'b1, 8'h00, 1'b1, 4'd0, 4'd8);
    checkOutput("boundary_aligned", 32'(cyc % PERIOD_CYC), 32'd0);
    countPeriod();
    checkOutput("boundary_old_duty", 32'(highCnt[0]), 32'd8);
    countPeriod();
    checkOutput("boundary_new_duty", 32'(highCnt[0]), 32'd16);

    // Out-of-range address sets the sticky error and changes nothing.
    applyStimulus(1'b1, 8'h00, 1'b1, 4'd12, 4'd7);
    checkOutput("wr_err_set", 32'(wr_err), 32'd1);
    applyStimulus(1'b1, 8'h00, 1'b1, 4'd1, 4'd3);
    applyStimulus(1'b1, 8'h00, 1'b1, 4'd2, 4'd6);
    checkOutput("wr_err_sticky", 32'(wr_err), 32'd1);
    toBoundary();
    countPeriod();
    checkOutput("after_err_ch0", 32'(highCnt[0]), 32'd16);
    checkOutput("after_err_ch1", 32'(highCnt[1]), 32'd6);
    checkOutput("after_err_ch2", 32'(highCnt[2]), 32'd12);
    checkOutput("after_err_ch10", 32'(highCnt[10]), 32'd32);

    // Asynchronous reset mid-period with channels lit.
    idle(10);
    checkOutput("pre_reset_lit", 32'(led[10]), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_led", 32'(led), 32'd0);
    checkOutput("async_wr_err", 32'(wr_err), 32'd0);
    checkOutput("async_period_start", 32'(period_start), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    modelReset();

    // First period_start after release arrives 32 cycles later.
    firstPs = -1;
    for (int k = 0; k < 40; k++) begin
      idle(1);
      if (period_start && firstPs < 0) firstPs = int'(cyc);
    end
    checkOutput("first_period_start", 32'(firstPs), 32'd32);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
